// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared widths and fetch-path record types.
// Revision : 1.0
// ============================================================================
package core_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [XLEN-1:0] pcadd4;
    logic            epoch;
  } fetch_tag_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pcadd4;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with registered storage, flush and occupancy.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush discards any same-cycle push as well as the stored contents.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction fetch unit feeding the IF/ID register; epoch-tagged
//            in-order requests, buffered responses, redirect kill.
//            Optional IF_PERF_CNT_EN adds fetch/drop counters.
// Revision : 1.0
// ============================================================================
module if_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            ifid_write,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     inst_if,
  output logic [XLEN-1:0] pcadd4_if,
  output logic            if_valid,
  output logic            if_flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  import core_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_tag_t      tag_in, tag_out;
  fetch_entry_t    ent_in, ent_out;
  logic [CW-1:0]   tag_cnt, buf_cnt;
  logic [CW:0]     credits_used;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            req_fire, rsp_pop, buf_push, buf_pop, buf_valid;

  // The pending-tag count doubles as the in-flight request count.
  assign credits_used   = {1'b0, tag_cnt} + {1'b0, buf_cnt};
  assign imem_req_valid = !rst && !pc_redirect && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_pop   = imem_rsp_valid && (tag_cnt != '0);
  assign buf_push  = rsp_pop && (tag_out.epoch == epoch_q) && !pc_redirect;
  assign buf_valid = (buf_cnt != '0);
  assign buf_pop   = ifid_write && buf_valid;

  assign tag_in = '{pcadd4: pc_q + XLEN'(4), epoch: epoch_q};
  assign ent_in = '{inst: imem_rsp_data, pcadd4: tag_out.pcadd4};

  fetch_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (tag_in),
    .pop   (rsp_pop),
    .rdata (tag_out),
    .count (tag_cnt)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (pc_redirect),
    .push  (buf_push),
    .wdata (ent_in),
    .pop   (buf_pop),
    .rdata (ent_out),
    .count (buf_cnt)
  );

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (pc_redirect) begin
      pc_d    = redirect_pc;
      epoch_d = ~epoch_q;
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  assign if_valid  = buf_valid;
  assign inst_if   = buf_valid ? ent_out.inst   : '0;
  assign pcadd4_if = buf_valid ? ent_out.pcadd4 : '0;
  assign if_flush  = pc_redirect && !rst;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(req_fire);
    drop_cnt_d  = drop_cnt_q + 32'(rsp_pop && !buf_push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`endif

endmodule
`default_nettype wire
